// File: rtl/thread_regfile_sb.sv
// thread_regfile_sb
// Per-thread register file with an integrated scoreboard.
//
// Address map (N = NUM_REGS):
//   0 .. N-4  writable general registers
//   N-3       %blockIdx  (loaded by block_start, read-only to write-back)
//   N-2       %blockDim  (constant THREADS_PER_BLOCK)
//   N-1       %threadIdx (constant THREAD_ID)
//
// Ports:
//   clk, reset         clock; synchronous active-high reset
//   enable             thread slot active; low freezes all state
//   block_start/_id    load %blockIdx
//   issue_*            decode-stage issue request (rs/rt sources, rd dest)
//   hazard             combinational stall indication
//   issue_accept       combinational accept (issue_valid & enable & !hazard)
//   rs_data/rt_data    registered operands, valid the cycle after accept
//   wb_*               write-back strobe, address and value
//   busy               OR of all pending bits (registered state)
//   wb_error           sticky: write-back to non-pending or read-only reg
module thread_regfile_sb #(
    parameter int NUM_REGS          = 16,
    parameter int DATA_BITS         = 8,
    parameter int THREADS_PER_BLOCK = 4,
    parameter int THREAD_ID         = 0,
    localparam int ADDR_BITS        = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 block_start,
    input  logic [DATA_BITS-1:0] block_id,
    input  logic                 issue_valid,
    input  logic                 issue_writes_rd,
    input  logic [ADDR_BITS-1:0] rs_addr,
    input  logic [ADDR_BITS-1:0] rt_addr,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic                 hazard,
    output logic                 issue_accept,
    output logic [DATA_BITS-1:0] rs_data,
    output logic [DATA_BITS-1:0] rt_data,
    input  logic                 wb_valid,
    input  logic [ADDR_BITS-1:0] wb_addr,
    input  logic [DATA_BITS-1:0] wb_data,
    output logic                 busy,
    output logic                 wb_error
);

    localparam logic [ADDR_BITS-1:0] IDX_BLOCKIDX  = ADDR_BITS'(NUM_REGS - 3);
    localparam logic [ADDR_BITS-1:0] IDX_BLOCKDIM  = ADDR_BITS'(NUM_REGS - 2);
    localparam logic [ADDR_BITS-1:0] IDX_THREADIDX = ADDR_BITS'(NUM_REGS - 1);
    localparam logic [DATA_BITS-1:0] BLOCK_DIM_VAL = DATA_BITS'(THREADS_PER_BLOCK);
    localparam logic [DATA_BITS-1:0] THREAD_ID_VAL = DATA_BITS'(THREAD_ID);

    // The special registers live in the same array as the general ones so
    // that reads are a single index; the two constants are simply never
    // written after reset.
    logic [DATA_BITS-1:0] regs_q [NUM_REGS];
    logic [DATA_BITS-1:0] regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]  pending_q, pending_d;
    logic [DATA_BITS-1:0] rs_q, rs_d, rt_q, rt_d;
    logic                 wb_error_q, wb_error_d;

    logic [NUM_REGS-1:0]  wb_hit;
    logic [NUM_REGS-1:0]  effpend;
    logic                 wb_writable;
    logic                 rd_writable;
    logic [DATA_BITS-1:0] rs_val, rt_val;

    assign wb_writable = (wb_addr < IDX_BLOCKIDX);
    assign rd_writable = (rd_addr < IDX_BLOCKIDX);

    // A write-back arriving this cycle resolves its register's dependency
    // immediately; the operand is then supplied through the bypass below.
    assign wb_hit  = wb_valid ? (NUM_REGS'(1) << wb_addr) : '0;
    assign effpend = pending_q & ~wb_hit;

    assign hazard = enable & issue_valid &
                    (effpend[rs_addr] | effpend[rt_addr] |
                     (issue_writes_rd & effpend[rd_addr]));
    assign issue_accept = issue_valid & enable & ~hazard;

    // Bypass only from writes that actually land; read-only targets drop them.
    assign rs_val = (wb_valid && wb_writable && wb_addr == rs_addr) ? wb_data : regs_q[rs_addr];
    assign rt_val = (wb_valid && wb_writable && wb_addr == rt_addr) ? wb_data : regs_q[rt_addr];

    always_comb begin
        regs_d     = regs_q;
        pending_d  = pending_q;
        rs_d       = rs_q;
        rt_d       = rt_q;
        wb_error_d = wb_error_q;
        if (enable) begin
            if (block_start) begin
                regs_d[IDX_BLOCKIDX] = block_id;
            end
            if (wb_valid) begin
                if (wb_writable) begin
                    regs_d[wb_addr]    = wb_data;
                    pending_d[wb_addr] = 1'b0;
                    if (!pending_q[wb_addr]) begin
                        wb_error_d = 1'b1;
                    end
                end else begin
                    wb_error_d = 1'b1;
                end
            end
            // Set after clear: a same-cycle retire and re-issue of one
            // register leaves it pending.
            if (issue_accept) begin
                rs_d = rs_val;
                rt_d = rt_val;
                if (issue_writes_rd && rd_writable) begin
                    pending_d[rd_addr] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            regs_q[IDX_BLOCKDIM]  <= BLOCK_DIM_VAL;
            regs_q[IDX_THREADIDX] <= THREAD_ID_VAL;
            pending_q  <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            wb_error_q <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            pending_q  <= pending_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            wb_error_q <= wb_error_d;
        end
    end

    assign rs_data  = rs_q;
    assign rt_data  = rt_q;
    assign busy     = |pending_q;
    assign wb_error = wb_error_q;

endmodule

// File: tb/tb_thread_regfile_sb.sv
// Testbench for thread_regfile_sb: directed scenarios on a 16x8 instance
// (THREAD_ID=2), randomized traffic against an array-based reference model,
// and a 32x16 instance for the wider parameter set.
module tb_thread_regfile_sb;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // 16 x 8 instance
    logic       en, bs, iv, iwr, wv;
    logic [7:0] bid, wd;
    logic [3:0] rs, rt, rd, wa;
    logic       hz, acc, busy, err;
    logic [7:0] rsd, rtd;

    // 32 x 16 instance
    logic        b_en, b_bs, b_iv, b_iwr, b_wv;
    logic [15:0] b_bid, b_wd;
    logic [4:0]  b_rs, b_rt, b_rd, b_wa;
    logic        b_hz, b_acc, b_busy, b_err;
    logic [15:0] b_rsd, b_rtd;

    thread_regfile_sb #(.NUM_REGS(16), .DATA_BITS(8), .THREADS_PER_BLOCK(4), .THREAD_ID(2)) dut_a (
        .clk(clk), .reset(reset), .enable(en), .block_start(bs), .block_id(bid),
        .issue_valid(iv), .issue_writes_rd(iwr), .rs_addr(rs), .rt_addr(rt), .rd_addr(rd),
        .hazard(hz), .issue_accept(acc), .rs_data(rsd), .rt_data(rtd),
        .wb_valid(wv), .wb_addr(wa), .wb_data(wd), .busy(busy), .wb_error(err)
    );

    thread_regfile_sb #(.NUM_REGS(32), .DATA_BITS(16), .THREADS_PER_BLOCK(4), .THREAD_ID(3)) dut_b (
        .clk(clk), .reset(reset), .enable(b_en), .block_start(b_bs), .block_id(b_bid),
        .issue_valid(b_iv), .issue_writes_rd(b_iwr), .rs_addr(b_rs), .rt_addr(b_rt), .rd_addr(b_rd),
        .hazard(b_hz), .issue_accept(b_acc), .rs_data(b_rsd), .rt_data(b_rtd),
        .wb_valid(b_wv), .wb_addr(b_wa), .wb_data(b_wd), .busy(b_busy), .wb_error(b_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge, away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        en = 1'b1; bs = 1'b0; bid = '0; iv = 1'b0; iwr = 1'b0;
        rs = '0; rt = '0; rd = '0; wv = 1'b0; wa = '0; wd = '0;
    endtask

    task automatic idle_b();
        b_en = 1'b1; b_bs = 1'b0; b_bid = '0; b_iv = 1'b0; b_iwr = 1'b0;
        b_rs = '0; b_rt = '0; b_rd = '0; b_wv = 1'b0; b_wa = '0; b_wd = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Plain read issue on instance A; operands visible after the edge.
    task automatic read_a(input logic [3:0] s, input logic [3:0] t);
        iv = 1'b1; iwr = 1'b0; rs = s; rt = t; rd = '0;
        tick();
        iv = 1'b0;
    endtask

    task automatic read_b(input logic [4:0] s, input logic [4:0] t);
        b_iv = 1'b1; b_iwr = 1'b0; b_rs = s; b_rt = t; b_rd = '0;
        tick();
        b_iv = 1'b0;
    endtask

    // Reference model state (16 x 8, blockDim 4, threadIdx 2)
    logic [7:0] m_reg [16];
    bit         m_pend [16];
    bit         m_err;
    logic [7:0] m_rs, m_rt;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_reg[i]  = 8'h00;
            m_pend[i] = 1'b0;
        end
        m_reg[14] = 8'd4;
        m_reg[15] = 8'd2;
        m_err = 1'b0;
        m_rs  = 8'h00;
        m_rt  = 8'h00;
    endtask

    function automatic bit m_busy();
        bit b = 1'b0;
        for (int i = 0; i < 16; i++) b |= m_pend[i];
        return b;
    endfunction

    // Is register r still waiting on a result, given this cycle's write-back?
    function automatic bit waiting(input int r);
        return m_pend[r] && !(wv && int'(wa) == r);
    endfunction

    // Value an issue sees for source r this cycle.
    function automatic logic [7:0] source_value(input int r);
        if (wv && int'(wa) == r && r < 13) return wd;
        return m_reg[r];
    endfunction

    initial begin
        reset = 1'b1;
        idle_a();
        idle_b();
        b_en = 1'b0;
        do_reset();

        // ---- reset state ----
        check("rst_rs_data", rsd, 8'h00);
        check("rst_rt_data", rtd, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_wb_error", err, 1'b0);
        read_a(4'd14, 4'd15);
        check("rst_blockdim", rsd, 8'd4);
        check("rst_threadidx", rtd, 8'd2);
        read_a(4'd13, 4'd0);
        check("rst_blockidx", rsd, 8'd0);
        check("rst_r0", rtd, 8'd0);

        // ---- RAW hazard resolved by same-cycle write-back bypass ----
        iv = 1'b1; iwr = 1'b1; rd = 4'd3; rs = 4'd0; rt = 4'd0;
        #1 check("raw_first_accept", acc, 1'b1);
        tick();
        iwr = 1'b0; rs = 4'd3; rt = 4'd1;
        #1 check("raw_hazard", hz, 1'b1);
        check("raw_no_accept", acc, 1'b0);
        check("raw_busy", busy, 1'b1);
        tick();
        check("raw_hazard_held", hz, 1'b1);
        wv = 1'b1; wa = 4'd3; wd = 8'h5A;
        #1 check("raw_wb_hazard", hz, 1'b0);
        check("raw_wb_accept", acc, 1'b1);
        tick();
        idle_a();
        check("raw_bypass_rs", rsd, 8'h5A);
        check("raw_busy_clear", busy, 1'b0);
        check("raw_no_error", err, 1'b0);

        // ---- same-cycle clear and set: set wins ----
        iv = 1'b1; iwr = 1'b1; rd = 4'd5;
        tick();
        wv = 1'b1; wa = 4'd5; wd = 8'h11;
        #1 check("clrset_accept", acc, 1'b1);
        tick();
        idle_a();
        check("clrset_busy", busy, 1'b1);
        iv = 1'b1; rs = 4'd5;
        #1 check("clrset_still_pending", hz, 1'b1);
        iv = 1'b0;
        wv = 1'b1; wa = 4'd5; wd = 8'h22;
        tick();
        idle_a();
        check("clrset_drain_busy", busy, 1'b0);
        check("clrset_no_error", err, 1'b0);
        read_a(4'd5, 4'd3);
        check("clrset_r5", rsd, 8'h22);
        check("clrset_r3", rtd, 8'h5A);

        // ---- enable low freezes state ----
        iv = 1'b1; iwr = 1'b1; rd = 4'd6;
        tick();
        idle_a();
        en = 1'b0; wv = 1'b1; wa = 4'd6; wd = 8'h77;
        tick();
        idle_a();
        check("freeze_busy", busy, 1'b1);
        check("freeze_no_error", err, 1'b0);
        iv = 1'b1; rs = 4'd6;
        #1 check("freeze_hazard", hz, 1'b1);
        iv = 1'b0; wv = 1'b1; wa = 4'd6; wd = 8'h66;
        tick();
        idle_a();
        read_a(4'd6, 4'd6);
        check("freeze_r6", rsd, 8'h66);

        // ---- write-back to a read-only register ----
        wv = 1'b1; wa = 4'd14; wd = 8'hFF;
        tick();
        idle_a();
        check("ro_wb_error", err, 1'b1);
        read_a(4'd14, 4'd15);
        check("ro_r14_kept", rsd, 8'd4);
        tick();
        tick();
        check("ro_error_sticky", err, 1'b1);

        // ---- block_start, with and without enable ----
        bs = 1'b1; bid = 8'd7;
        tick();
        idle_a();
        read_a(4'd13, 4'd15);
        check("blk_idx", rsd, 8'd7);
        en = 1'b0; bs = 1'b1; bid = 8'd9; iv = 1'b1; rs = 4'd14; rt = 4'd14;
        #1 check("blk_dis_hazard", hz, 1'b0);
        check("blk_dis_accept", acc, 1'b0);
        tick();
        idle_a();
        check("blk_dis_rs_held", rsd, 8'd7);
        read_a(4'd13, 4'd13);
        check("blk_idx_kept", rsd, 8'd7);

        // ---- reset in the middle of outstanding work ----
        iv = 1'b1; iwr = 1'b1; rd = 4'd7;
        tick();
        idle_a();
        check("midrst_busy_before", busy, 1'b1);
        do_reset();
        check("midrst_busy", busy, 1'b0);
        check("midrst_error", err, 1'b0);
        check("midrst_rs", rsd, 8'd0);
        wv = 1'b1; wa = 4'd7; wd = 8'h01;
        tick();
        idle_a();
        check("midrst_late_wb_error", err, 1'b1);

        // ---- randomized traffic against the reference model ----
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            int pend_q[$];
            bit exp_hz, exp_acc;
            logic [7:0] src_s, src_t;

            if (cyc == 300) begin
                idle_a();
                do_reset();
                model_reset();
                check("rnd_reset_busy", busy, 1'b0);
            end

            for (int i = 0; i < 13; i++) if (m_pend[i]) pend_q.push_back(i);
            en  = ($urandom_range(9) != 0);
            bs  = ($urandom_range(7) == 0);
            bid = 8'($urandom);
            iv  = ($urandom_range(3) != 0);
            iwr = $urandom_range(1);
            rs  = 4'($urandom_range(15));
            rt  = 4'($urandom_range(15));
            rd  = 4'($urandom_range(15));
            if (pend_q.size() > 0 && $urandom_range(2) != 0) begin
                wv = 1'b1;
                wa = 4'(pend_q[$urandom_range(pend_q.size() - 1)]);
            end else begin
                wv = ($urandom_range(5) == 0);
                wa = 4'($urandom_range(12));
            end
            wd = 8'($urandom);
            #1;

            exp_hz  = en && iv && (waiting(rs) || waiting(rt) || (iwr && waiting(rd)));
            exp_acc = en && iv && !exp_hz;
            check("rnd_hazard", hz, exp_hz);
            check("rnd_accept", acc, exp_acc);

            src_s = source_value(rs);
            src_t = source_value(rt);
            if (en) begin
                if (bs) m_reg[13] = bid;
                if (wv) begin
                    if (wa < 13) begin
                        if (!m_pend[wa]) m_err = 1'b1;
                        m_reg[wa]  = wd;
                        m_pend[wa] = 1'b0;
                    end else begin
                        m_err = 1'b1;
                    end
                end
                if (exp_acc) begin
                    m_rs = src_s;
                    m_rt = src_t;
                    if (iwr && rd < 13) m_pend[rd] = 1'b1;
                end
            end

            tick();
            check("rnd_rs_data", rsd, m_rs);
            check("rnd_rt_data", rtd, m_rt);
            check("rnd_busy", busy, m_busy());
            check("rnd_wb_error", err, m_err);
        end
        idle_a();

        // ---- 32 x 16 parameter set ----
        idle_b();
        do_reset();
        check("p32_rst_error", b_err, 1'b0);
        read_b(5'd30, 5'd31);
        check("p32_blockdim", b_rsd, 16'd4);
        check("p32_threadidx", b_rtd, 16'd3);
        b_wv = 1'b1; b_wa = 5'd29; b_wd = 16'h1234;
        tick();
        idle_b();
        check("p32_ro_error", b_err, 1'b1);
        read_b(5'd29, 5'd28);
        check("p32_r29_dropped", b_rsd, 16'h0000);
        b_wv = 1'b1; b_wa = 5'd28; b_wd = 16'hBEEF;
        tick();
        idle_b();
        read_b(5'd28, 5'd29);
        check("p32_r28", b_rsd, 16'hBEEF);
        check("p32_r29_still", b_rtd, 16'h0000);
        b_bs = 1'b1; b_bid = 16'h0042;
        tick();
        idle_b();
        read_b(5'd29, 5'd0);
        check("p32_blockidx", b_rsd, 16'h0042);
        check("p32_busy", b_busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/thread_regfile_sb.md
# thread_regfile_sb

Per-thread register file with integrated scoreboard for the pipelined core. It generalises the fixed 16×8 thread register file to NUM_REGS × DATA_BITS, with registered read ports, same-cycle write-back bypass and per-register pending tracking. The decode stage uses it to hold back instructions whose operands are still in flight, and the write-back stage uses it to retire results. One instance exists per thread slot in each core.

## Interface
- NUM_REGS, 16, register count; power of 2, ≥ 8; ADDR_BITS = $clog2(NUM_REGS)
- DATA_BITS, 8, register width
- THREADS_PER_BLOCK, 4, value of %blockDim, truncated to DATA_BITS
- THREAD_ID, 0, value of %threadIdx, truncated to DATA_BITS
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- enable  in  1  thread slot active; when low, no state changes except reset
- block_start  in  1  latch block_id into %blockIdx
- block_id  in  DATA_BITS  block index of the dispatched block
- issue_valid  in  1  decode presents an instruction
- issue_writes_rd  in  1  instruction will produce a result in rd
- rs_addr, rt_addr, rd_addr  in  ADDR_BITS  source and destination addresses
- hazard  out  1  combinational; issue is blocked this cycle
- issue_accept  out  1  combinational; issue_valid & enable & !hazard
- rs_data, rt_data  out  DATA_BITS  registered operand values
- wb_valid  in  1  write-back strobe
- wb_addr  in  ADDR_BITS  write-back address
- wb_data  in  DATA_BITS  write-back value
- busy  out  1  registered-state OR of all pending bits
- wb_error  out  1  sticky; set by write-back to a non-pending or read-only register

## Operation
- Address map:
  - 0..NUM_REGS-4 are writable.
  - NUM_REGS-3 is %blockIdx.
  - NUM_REGS-2 is %blockDim.
  - NUM_REGS-1 is %threadIdx.
  - Addresses at or above NUM_REGS-3 are read-only (RO).
- Scoreboard: one pending bit per writable register. RO registers are never pending.
- Effective pending of register r in a cycle: pending[r] & !(wb_valid & wb_addr==r).
- hazard = enable & issue_valid & (effpend[rs] | effpend[rt] | (issue_writes_rd & effpend[rd])). hazard is 0 when enable is low.
- Accepted issue:
  - Captures rs_data and rt_data at the clock edge.
  - If issue_writes_rd is set and rd is writable, sets pending[rd].
  - If rd is RO, no bit is set and the result is later discarded.
- Read bypass: if wb_valid and wb_addr equals a source address in the accept cycle, that operand captures wb_data, not the array value.
- Write-back (enable high):
  - If wb_addr is writable, writes wb_data and clears pending[wb_addr].
  - If wb_addr is RO, drops the write and sets wb_error.
  - If pending[wb_addr] is 0, still writes and sets wb_error.
- Simultaneous clear and set of the same register in one cycle: the set wins, so the bit stays pending.
- block_start & enable loads %blockIdx <= block_id. It is independent of issue and write-back.
- When not accepted, rs_data and rt_data hold their previous values.

## Timing
- Reset values:
  - All writable registers and %blockIdx are 0.
  - %blockDim = THREADS_PER_BLOCK[DATA_BITS-1:0].
  - %threadIdx = THREAD_ID[DATA_BITS-1:0].
  - pending = 0, rs_data = rt_data = 0, busy = 0, wb_error = 0.
- Reset mid-operation discards all pending bits. Write-backs arriving after reset that target now non-pending registers set wb_error.
- Read latency is 1 cycle: operands are valid the cycle after issue_accept.
- A write-back in cycle N is visible to an issue in cycle N (via bypass) and to any later issue.
- hazard and issue_accept depend combinationally on issue inputs, wb inputs and pending state. There is no path from outputs back to inputs.
- busy reflects pending after the edge, i.e. it is registered state.
- A fully pending scoreboard has no special case: every dependent issue stalls until its write-back arrives.
- enable low freezes all state: pending, array, operands and wb_error. Write-backs and block_start are ignored while enable is low.

## Test plan
- Reset with NUM_REGS=16, THREADS_PER_BLOCK=4, THREAD_ID=2 -> reading r14 gives 4, r15 gives 2, r13 gives 0; busy=0, wb_error=0.
- Issue rd=3 with writes_rd, then issue rs=3 -> hazard=1 until wb_addr=3, wb_data=0x5A. In the write-back cycle hazard=0, accept happens, and rs_data=0x5A next cycle (bypass).
- Same cycle: wb clears r5 and an accepted issue sets rd=5 -> pending[5] stays 1, busy=1.
- wb_addr=14 with data 0xFF -> r14 still reads 4, wb_error=1 and stays 1 until reset.
- block_start with block_id=7, then read r13 -> 7. Repeat with enable=0 and block_id=9 -> r13 stays 7, hazard=0, no accept.
- Parameter sweep NUM_REGS=32, DATA_BITS=16 -> r29 is %blockIdx; a write to r28 of 0xBEEF reads back 0xBEEF; a write to r29 is dropped and flags wb_error.
